key_event_fifo: RTL

- Sits directly downstream of the SSD1306/keyboard SPI driver. Consumes its 8-bit key-event byte, where 8'h00 means no key and any nonzero value is the code of the held key.
- Converts level changes on that byte into discrete press/release events and buffers them in a small FIFO.
- Presents the events on a valid/ready handshake to the consumer (display latch, future command logic).
- Also holds the last popped press code so it can drive DoubleDigitDisplay directly.

---
 rtl/key_event_fifo.sv | 111 +++++++++++
 1 files changed

// File: rtl/key_event_fifo.sv
// key_event_fifo
// Turns level changes on the keyboard driver's key byte into press/release
// events, queues them in a small circular FIFO and hands them to a consumer
// over a valid/ready handshake. Also remembers the last popped press code
// so the two-digit display can be driven straight from this block.

module key_event_fifo #(
    parameter int unsigned DEPTH          = 8,
    parameter bit          RELEASE_EVENTS = 1'b1
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic [7:0]               i_Key_Code,
    output logic [8:0]               o_Event,
    output logic                     o_Valid,
    input  logic                     i_Ready,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Overflow,
    output logic [7:0]               o_Last_Code
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    prev_code_q, prev_code_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    last_code_q, last_code_d;
    logic [8:0]    mem_q [DEPTH];

    logic          push_req;
    logic [8:0]    push_event;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          not_empty;
    logic [8:0]    head_event;

    // Decide which event (if any) the current key byte implies relative to last cycle
    always_comb begin
        push_req   = 1'b0;
        push_event = 9'h000;
        if (prev_code_q == 8'h00 && i_Key_Code != 8'h00) begin
            push_req   = 1'b1;
            push_event = {1'b0, i_Key_Code};
        end else if (prev_code_q != 8'h00 && i_Key_Code == 8'h00) begin
            if (RELEASE_EVENTS) begin
                push_req   = 1'b1;
                push_event = {1'b1, prev_code_q};
            end
        end else if (i_Key_Code != prev_code_q) begin
            // Rolling straight from one key to another reports only the new press
            push_req   = 1'b1;
            push_event = {1'b0, i_Key_Code};
        end
    end

    // FIFO bookkeeping: a pop frees a slot in the same cycle, so a full FIFO can still accept a push while popping
    always_comb begin
        not_empty   = (count_q != '0);
        full        = (count_q == CW'(DEPTH));
        head_event  = mem_q[rd_ptr_q];
        pop         = not_empty && i_Ready;
        push_ok     = push_req && (!full || pop);

        prev_code_d = i_Key_Code;
        rd_ptr_d    = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d    = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d     = count_q + CW'(push_ok) - CW'(pop);
        overflow_d  = overflow_q | (push_req && !push_ok);
        last_code_d = last_code_q;
        if (pop && !head_event[8]) begin
            last_code_d = head_event[7:0];
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            prev_code_q <= 8'h00;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            last_code_q <= 8'h00;
        end else begin
            prev_code_q <= prev_code_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            last_code_q <= last_code_d;
        end
    end

    // Event storage; contents need no reset because the head is masked while empty
    always_ff @(posedge i_Clk) begin
        if (i_Rst_L && push_ok) begin
            mem_q[wr_ptr_q] <= push_event;
        end
    end

    assign o_Valid     = not_empty;
    assign o_Event     = not_empty ? head_event : 9'h000;
    assign o_Count     = count_q;
    assign o_Overflow  = overflow_q;
    assign o_Last_Code = last_code_q;

endmodule
